// File: rtl/pkt_ingress_buffer.sv
// Store-and-forward ingress buffer: holds packets until complete,
// forwards each as one burst followed by an idle gap.
`timescale 1ns/1ps
module pkt_ingress_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_BITS  = 9,
  parameter int CNT_BITS   = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [CNT_BITS-1:0]   pkt_count,
  output logic [CNT_BITS-1:0]   drop_count
);

  localparam int DEPTH  = 2 ** ADDR_BITS;
  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_BITS:0] FULL_OCC =
    (ADDR_BITS + 1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_CYCLES - 1);

  typedef enum logic {
    W_ACCEPT,
    W_DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SEND,
    R_GAP
  } rd_state_t;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [WORD_W-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]     eop_flag;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] commit_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   occ;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 prev_zero;

  logic full;
  logic is_eop;
  logic wr_en;
  logic drop;
  logic drop_in;
  logic take;
  logic commit;
  logic rd_en;
  logic pkt_dec;

  assign full    = (occ == FULL_OCC);
  assign is_eop  = prev_zero && (in_ctrl != '0);
  assign wr_en   = (w_state == W_ACCEPT) && in_wr && !full;
  assign drop    = (w_state == W_ACCEPT) && in_wr && full;
  assign drop_in = (w_state == W_DROP) && in_wr;
  assign take    = wr_en || drop || drop_in;
  assign commit  = wr_en && is_eop;

  // Reads only ever cover committed words, so a live packet
  // count is the guard that keeps partial packets hidden.
  assign rd_en   = (r_state == R_SEND) && out_rdy
                && (pkt_count != '0);
  assign pkt_dec = rd_en && eop_flag[rd_ptr];

  assign in_rdy = (w_state == W_DROP) || !full
               || (pkt_count == '0 && rd_ptr == commit_ptr);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_ACCEPT: if (drop && !is_eop) w_next = W_DROP;
      W_DROP:   if (drop_in && is_eop) w_next = W_ACCEPT;
      default:  w_next = W_ACCEPT;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (pkt_count != '0) r_next = R_SEND;
      R_SEND:  if (pkt_dec) r_next = R_GAP;
      R_GAP:   if (gap_cnt >= GAP_LAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state    <= W_ACCEPT;
      r_state    <= R_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      gap_cnt    <= '0;
      prev_zero  <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      else if (drop) wr_ptr <= commit_ptr;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (drop) occ <= {1'b0, commit_ptr - rd_ptr};
      else if (wr_en && !rd_en) occ <= occ + 1'b1;
      else if (rd_en && !wr_en) occ <= occ - 1'b1;
      // Tracks every word seen, kept or discarded, so EOP is
      // still found while a packet is being thrown away.
      if (take) prev_zero <= (in_ctrl == '0);
      if (commit && !pkt_dec) pkt_count <= pkt_count + 1'b1;
      else if (pkt_dec && !commit) pkt_count <= pkt_count - 1'b1;
      if (drop && drop_count != '1)
        drop_count <= drop_count + 1'b1;
      if (pkt_dec) gap_cnt <= GAP_W'(1);
      else if (r_state == R_GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]      <= {in_ctrl, in_data};
      eop_flag[wr_ptr] <= is_eop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= rd_en;
      if (rd_en) {out_ctrl, out_data} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pkt_ingress_buffer.sv
// Self-checking bench for pkt_ingress_buffer (16-word buffer),
// directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_pkt_ingress_buffer;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [7:0]  pkt_count;
  logic [7:0]  drop_count;

  pkt_ingress_buffer #(
    .DATA_WIDTH(64),
    .CTRL_WIDTH(8),
    .ADDR_BITS (4),
    .CNT_BITS  (8),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wr     (in_wr),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wr    (out_wr),
    .out_rdy   (out_rdy),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    bit          first;
    bit          last;
  } ent_t;

  ent_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int words_out = 0;
  int words_sent = 0;
  int drop_exp = 0;
  int first_cyc = 0;
  int eop_cyc = 0;
  int last_gap = 0;
  int last_span = 0;
  bit seen_eop = 0;
  bit prev_rdy = 0;
  bit done = 0;
  logic [71:0] last_word = '0;

  task automatic check(input string tag,
                       input logic [71:0] obs,
                       input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output scoreboard: order, ctrl, hold, gap, backpressure.
  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      seen_eop = 0;
      prev_rdy = 0;
      last_word = {out_ctrl, out_data};
    end else begin
      if (out_wr) begin
        check("wr_after_rdy", prev_rdy, 1);
        if (exp_q.size() == 0) begin
          check("spurious_out_wr", out_wr, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {out_ctrl, out_data}, e.w);
          if (e.first) begin
            if (seen_eop) begin
              last_gap = cyc - eop_cyc - 1;
              check("gap_min", last_gap >= GAP, 1);
            end
            first_cyc = cyc;
          end
          if (e.last) begin
            eop_cyc = cyc;
            seen_eop = 1;
            last_span = cyc - first_cyc;
          end
        end
        words_out++;
      end else begin
        check("hold", {out_ctrl, out_data}, last_word);
      end
      last_word = {out_ctrl, out_data};
      prev_rdy = out_rdy;
    end
  end

  task automatic push_exp(input logic [7:0] c,
                          input logic [63:0] d,
                          input bit f, input bit l);
    ent_t e;
    e.w = {c, d};
    e.first = f;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [7:0] c,
                           input logic [63:0] d);
    int n = 0;
    while (!in_rdy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_rdy_wait", in_rdy, 1);
    in_wr = 1'b1;
    in_ctrl = c;
    in_data = d;
    @(posedge clk); #1;
    in_wr = 1'b0;
    words_sent++;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] lc);
    logic [7:0] c;
    logic [63:0] d;
    logic [7:0] lcx;
    bit fits;
    fits = (len <= DEPTH);
    lcx = (lc != 0) ? lc : 8'($urandom_range(1, 255));
    if (!fits) drop_exp = (drop_exp == 255) ? 255 : drop_exp + 1;
    for (int i = 0; i < len; i++) begin
      c = (i == 0) ? 8'hFF : (i == len - 1) ? lcx : 8'h00;
      d = {$urandom, $urandom};
      if (fits) push_exp(c, d, i == 0, i == len - 1);
      send_word(c, d);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || pkt_count != 0 || out_wr)
           && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_pkt_count", pkt_count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int len;
    logic [63:0] d;
    reset = 1'b1;
    in_wr = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_wr", out_wr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_in_rdy", in_rdy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_rdy_after_rst", in_rdy, 1);

    // Single 6-word packet, EOP ctrl 0x01
    out_rdy = 1'b1;
    base = words_out;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      push_exp(i == 0 ? 8'hFF : 8'h00, d, i == 0, 0);
      send_word(i == 0 ? 8'hFF : 8'h00, d);
    end
    check("single_pre_eop_cnt", pkt_count, 0);
    d = {$urandom, $urandom};
    push_exp(8'h01, d, 0, 1);
    send_word(8'h01, d);
    check("single_eop_cnt", pkt_count, 1);
    wait_drain();
    check("single_words", words_out - base, 6);
    check("single_span", last_span, 5);

    // Back-to-back 5-word packets
    base = words_out;
    send_pkt(5, 0);
    send_pkt(5, 0);
    wait_drain();
    check("b2b_words", words_out - base, 10);
    check("b2b_gap", last_gap, GAP);
    check("b2b_span", last_span, 4);

    // Backpressure: toggling out_rdy
    out_rdy = 1'b0;
    base = words_out;
    send_pkt(6, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      out_rdy = ~out_rdy;
      n++;
    end
    out_rdy = 1'b1;
    wait_drain();
    check("bp_words", words_out - base, 6);

    // Buffer full: two 10-word packets, reader stalled
    out_rdy = 1'b0;
    base = words_sent;
    n = words_out;
    fork
      begin
        send_pkt(10, 0);
        send_pkt(10, 0);
      end
      begin
        int k;
        k = 0;
        while (words_sent - base < 16 && k < 100) begin
          @(posedge clk); #1;
          k++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("full_in_rdy", in_rdy, 0);
        check("full_accepted", words_sent - base, 16);
        check("full_pkt_count", pkt_count, 1);
        out_rdy = 1'b1;
      end
    join
    wait_drain();
    check("full_words", words_out - n, 20);
    check("full_drops", drop_count, drop_exp);

    // Oversize packet dropped, following packet kept
    out_rdy = 1'b0;
    base = words_out;
    send_pkt(20, 0);
    send_pkt(3, 0);
    repeat (2) @(posedge clk);
    #1;
    check("ovs_drop_count", drop_count, 1);
    check("ovs_pkt_count", pkt_count, 1);
    out_rdy = 1'b1;
    wait_drain();
    check("ovs_words", words_out - base, 3);

    // Async reset in the middle of a burst
    base = words_out;
    send_pkt(12, 0);
    n = 0;
    while (words_out - base < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_wr", out_wr, 0);
    check("arst_pkt_count", pkt_count, 0);
    check("arst_in_rdy", in_rdy, 1);
    check("arst_drop_count", drop_count, 0);
    exp_q.delete();
    drop_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = words_out;
    send_pkt(5, 0);
    wait_drain();
    check("arst_next_words", words_out - base, 5);
    check("arst_next_span", last_span, 4);

    // Random traffic with random backpressure
    done = 0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          if ($urandom_range(0, 7) == 0)
            len = int'($urandom_range(19, 24));
          else
            len = int'($urandom_range(3, 16));
          send_pkt(len, 0);
        end
        done = 1;
      end
      begin
        int k;
        k = 0;
        while (!done && k < 30000) begin
          @(posedge clk); #1;
          out_rdy = 1'($urandom_range(0, 1));
          k++;
        end
        out_rdy = 1'b1;
      end
    join
    wait_drain();
    check("rand_drops", drop_count, drop_exp);

    // drop_count saturates at all-ones
    for (int p = 0; p < 257; p++) send_pkt(19, 0);
    repeat (2) @(posedge clk);
    #1;
    check("sat_drop_count", drop_count, drop_exp);
    check("sat_pkt_count", pkt_count, 0);
    check("sat_in_rdy", in_rdy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
